alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer side of the ALU operand/function interface (`fn`, `funct7`, `a`, `b`).
- Accepts one RV32I instruction per handshake, with the already-read rs1/rs2 values.
- Decodes OP (0110011) and OP-IMM (0010011) into the `ALU_FN` encoding and presents the result to the ALU through a registered valid/ready output.
- A 2-entry skid buffer decouples the upstream fetch/regfile stage from ALU/writeback backpressure.

Parameters:
- WIDTH, 32, datapath width of rs1/rs2/a/b; immediates are sign-extended to WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction + operands valid.
- in_ready  out  1  stage can accept; registered output.
- in_inst  in  32  raw instruction word.
- in_rs1  in  WIDTH  rs1 value.
- in_rs2  in  WIDTH  rs2 value.
- out_valid  out  1  ALU request valid.
- out_ready  in  1  ALU/writeback accepts the request.
- fn  out  3  ALU_FN code; equals inst[14:12].
- funct7  out  7  bits [31:25] sent to the ALU.
- a  out  WIDTH  operand A (rs1).
- b  out  WIDTH  operand B (rs2, imm, or shamt).
- rd  out  5  destination register, inst[11:7].
- illegal  out  1  qualified by out_valid; opcode is not OP/OP-IMM, or the funct7 is illegal.

Behaviour:
- Reset (async, immediate on rst rising): both skid entries invalid; out_valid=0, in_ready=1, illegal=0, fn/funct7/a/b/rd=0. Held while rst=1.
- Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Latency: 1 cycle. An accepted instruction appears on the outputs the next cycle if the buffer was empty.
- Throughput: 1 per cycle while out_ready=1.
- Decode, OP:
  - a=rs1, b=rs2, funct7=inst[31:25].
  - illegal=1 unless funct7 is 0000000, or 0100000 with funct3 ∈ {000, 101}.
- Decode, OP-IMM, non-shift (funct3 ∉ {001, 101}):
  - a=rs1, b=sext(inst[31:20]).
  - funct7 forced to 0000000, so ADDI with imm[10]=1 is never treated as SUB.
- Decode, OP-IMM, shift (funct3 ∈ {001, 101}):
  - a=rs1, b=zero-extended inst[24:20].
  - funct7=inst[31:25].
  - illegal=1 unless funct7=0000000, or funct7=0100000 with funct3=101.
- Any other opcode: illegal=1, fn/funct7/a/b=0, rd passed through.
- Illegal instructions still occupy a slot and need an out handshake; the consumer discards them.
- Skid buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Skid buffer transitions:
  - EMPTY→ONE on input accept.
  - ONE→FULL on accept without output transfer.
  - ONE→EMPTY on output transfer without accept.
  - ONE→ONE on simultaneous accept and transfer.
  - FULL→ONE on output transfer.
- Ordering is strictly FIFO. The output always comes from the oldest entry.
- in_ready is registered. It is derived from next-state ≠ FULL and is never combinationally dependent on out_ready.
- Output fields stay stable while out_valid=1 && out_ready=0.
- in_valid while in_ready=0: ignored, no state change.
- Reset mid-operation: in-flight entries are dropped and no out_valid pulse occurs after rst deasserts until a new accept.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined:
  - Adds outputs stat_issued[31:0] and stat_illegal[31:0], reset to 0.
  - stat_issued increments on every output transfer.
  - stat_illegal increments on output transfers with illegal=1.
  - Both counters wrap at 2^32−1 → 0.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- SUB: in_inst=0x40000033, rs1=23, rs2=11, out_ready=1 → next cycle out_valid=1, fn=000, funct7=0100000, a=23, b=11, illegal=0.
- ADDI -1: in_inst=0xFFF00013, rs1=5 → fn=000, funct7=0000000, b=0xFFFFFFFF, illegal=0.
- SRAI 5: in_inst=0x40505013 → fn=101, funct7=0100000, b=5; in_inst=0x40501013 (SLLI, bad funct7) → illegal=1.
- ECALL: in_inst=0x00000073 → out_valid=1, illegal=1, a=b=0.
- Backpressure:
  - Setup: 3 back-to-back ANDs with rs1=1,2,3; out_ready=0.
  - Expect: in_ready low after the 2nd accept; the 3rd is held upstream.
  - Release out_ready=1: outputs a=1,2,3 in order, with no loss or duplication.
- Reset mid-flight: 2 entries buffered, pulse rst asynchronously → out_valid=0 and in_ready=1 immediately; no stale output afterwards.
- With ALU_ISSUE_STATS_EN defined: 4 issues, 1 of them illegal → stat_issued=4, stat_illegal=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I OP/OP-IMM into ALU requests behind a 2-entry skid buffer.
// Optional macro ALU_ISSUE_STATS_EN adds issued/illegal transfer counters.
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [WIDTH-1:0] in_rs1,
  input  logic [WIDTH-1:0] in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       fn,
  output logic [6:0]       funct7,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [4:0]       rd,
  output logic             illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_illegal
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [2:0]       fn;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       rd;
    logic             illegal;
  } ent_t;
  state_t state_q, state_d;
  ent_t dec, head_q, head_d, tail_q, tail_d;
  logic in_ready_q, in_ready_d, acc, xfer, shift;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^in_inst[19:15];
  assign opc = in_inst[6:0];
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];
  assign shift = (f3 == 3'b001) || (f3 == 3'b101);
  always_comb begin
    dec = '0;
    dec.rd = in_inst[11:7];
    if (opc == 7'b0110011) begin
      dec.fn = f3;
      dec.funct7 = f7;
      dec.a = in_rs1;
      dec.b = in_rs2;
      dec.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
    end else if (opc == 7'b0010011) begin
      dec.fn = f3;
      dec.a = in_rs1;
      // non-shift immediates never carry funct7, so ADDI with imm[10]=1 stays an add
      dec.funct7 = shift ? f7 : 7'h00;
      dec.b = shift ? WIDTH'(in_inst[24:20]) : {{(WIDTH-12){in_inst[31]}}, in_inst[31:20]};
      dec.illegal = shift && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b101));
    end else begin
      dec.illegal = 1'b1;
    end
  end
  assign acc = in_valid && in_ready_q;
  assign xfer = (state_q != EMPTY) && out_ready;
  always_comb begin
    state_d = state_q;
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        head_d = dec;
      end
      ONE: if (acc && xfer) begin
        head_d = dec;
      end else if (acc) begin
        state_d = FULL;
        tail_d = dec;
      end else if (xfer) begin
        state_d = EMPTY;
      end
      FULL: if (xfer) begin
        state_d = ONE;
        head_d = tail_q;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = state_d != FULL;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= EMPTY;
      in_ready_q <= 1'b1;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  assign in_ready = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign fn = head_q.fn;
  assign funct7 = head_q.funct7;
  assign a = head_q.a;
  assign b = head_q.b;
  assign rd = head_q.rd;
  assign illegal = head_q.illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] iss_q, iss_d, ill_q, ill_d;
  always_comb begin
    iss_d = xfer ? iss_q + 32'd1 : iss_q;
    ill_d = (xfer && head_q.illegal) ? ill_q + 32'd1 : ill_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      iss_q <= '0;
      ill_q <= '0;
    end else begin
      iss_q <= iss_d;
      ill_q <= ill_d;
    end
  assign stat_issued = iss_q;
  assign stat_illegal = ill_q;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed decode vectors plus backpressure, reset and stats sequences.
module tb_alu_issue_stage;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, illegal;
  logic [31:0] in_inst = 0, in_rs1 = 0, in_rs2 = 0, a, b;
  logic [2:0] fn;
  logic [6:0] funct7;
  logic [4:0] rd;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_illegal;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  alu_issue_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .fn(fn), .funct7(funct7), .a(a), .b(b), .rd(rd), .illegal(illegal)
`ifdef ALU_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_illegal(stat_illegal)
`endif
  );
  typedef struct {
    logic [31:0] inst, rs1, rs2;
    logic [2:0]  fn;
    logic [6:0]  f7;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        ill;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1;
    in_inst = inst;
    in_rs1 = r1;
    in_rs2 = r2;
  endtask
  initial begin
    v[0]  = '{32'h40000033, 32'd23, 32'd11, 3'd0, 7'h20, 32'd23, 32'd11, 5'd0, 1'b0};
    v[1]  = '{32'hFFF00013, 32'd5, 32'd9, 3'd0, 7'h00, 32'd5, 32'hFFFFFFFF, 5'd0, 1'b0};
    v[2]  = '{32'h40505013, 32'h80000000, 32'd7, 3'd5, 7'h20, 32'h80000000, 32'd5, 5'd0, 1'b0};
    v[3]  = '{32'h40501013, 32'd12, 32'd7, 3'd1, 7'h20, 32'd12, 32'd5, 5'd0, 1'b1};
    v[4]  = '{32'h00000073, 32'd44, 32'd55, 3'd0, 7'h00, 32'd0, 32'd0, 5'd0, 1'b1};
    v[5]  = '{32'h002081B3, 32'd100, 32'd200, 3'd0, 7'h00, 32'd100, 32'd200, 5'd3, 1'b0};
    v[6]  = '{32'h40002033, 32'd6, 32'd7, 3'd2, 7'h20, 32'd6, 32'd7, 5'd0, 1'b1};
    v[7]  = '{32'h40000293, 32'd8, 32'd9, 3'd0, 7'h00, 32'd8, 32'h400, 5'd5, 1'b0};
    v[8]  = '{32'h00305093, 32'hF0, 32'd1, 3'd5, 7'h00, 32'hF0, 32'd3, 5'd1, 1'b0};
    v[9]  = '{32'h123453B7, 32'd1, 32'd2, 3'd0, 7'h00, 32'd0, 32'd0, 5'd7, 1'b1};
    v[10] = '{32'h41F05013, 32'hFFFFFFFF, 32'd0, 3'd5, 7'h20, 32'hFFFFFFFF, 32'd31, 5'd0, 1'b0};
    v[11] = '{32'h40005033, 32'hFFFFFFF8, 32'd2, 3'd5, 7'h20, 32'hFFFFFFF8, 32'd2, 5'd0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    chk("rst.a", a, 32'd0);
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      drive(v[i].inst, v[i].rs1, v[i].rs2);
      @(negedge clk);
      chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d.fn", i), {29'd0, fn}, {29'd0, v[i].fn});
      chk($sformatf("v%0d.funct7", i), {25'd0, funct7}, {25'd0, v[i].f7});
      chk($sformatf("v%0d.a", i), a, v[i].a);
      chk($sformatf("v%0d.b", i), b, v[i].b);
      chk($sformatf("v%0d.rd", i), {27'd0, rd}, {27'd0, v[i].rd});
      chk($sformatf("v%0d.illegal", i), {31'd0, illegal}, {31'd0, v[i].ill});
    end
    in_valid = 0;
    @(negedge clk);
    chk("drain.out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 0;
    drive(32'h00007033, 32'd1, 32'd0);
    @(negedge clk);
    chk("bp1.in_ready", {31'd0, in_ready}, 32'd1);
    drive(32'h00007033, 32'd2, 32'd0);
    @(negedge clk);
    chk("bp2.in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp2.a", a, 32'd1);
    drive(32'h00007033, 32'd3, 32'd0);
    @(negedge clk);
    chk("bp3.in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp3.hold_a", a, 32'd1);
    chk("bp3.fn", {29'd0, fn}, 32'd7);
    out_ready = 1;
    @(negedge clk);
    chk("bp4.a", a, 32'd2);
    chk("bp4.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("bp5.a", a, 32'd3);
    in_valid = 0;
    @(negedge clk);
    chk("bp6.out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 0;
    drive(32'h00007033, 32'd7, 32'd0);
    @(negedge clk);
    drive(32'h00007033, 32'd8, 32'd0);
    @(negedge clk);
    in_valid = 0;
    chk("mid.full_valid", {31'd0, out_valid}, 32'd1);
    chk("mid.full_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1;
    #1;
    chk("mid.rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid.rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid.rst_a", a, 32'd0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid.stale%0d", i), {31'd0, out_valid}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(v[i].inst, v[i].rs1, v[i].rs2);
      @(negedge clk);
    end
    in_valid = 0;
    @(negedge clk);
    chk("stats.drained", {31'd0, out_valid}, 32'd0);
`ifdef ALU_ISSUE_STATS_EN
    chk("stats.issued", stat_issued, 32'd4);
    chk("stats.illegal", stat_illegal, 32'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
